// File: rtl/sample_stream_pkg.sv
// Shared types and defaults for the sample stream transmitter and its FIFO.
package sample_stream_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_DEF  = 8;
    localparam int GAP_W_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Occupancy needs one extra bit so that a full FIFO (level == DEPTH) is representable.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with registered head/level/full/empty; push+pop is legal even when full.
module sample_fifo
    import sample_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push_ok, pop_ok;

    // A pop frees the slot being written, so a push while full is fine if it pairs with a pop.
    assign pop_ok  = pop && !empty_q;
    assign push_ok = push && (!full_q || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == LW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/sample_stream_tx.sv
// Drains the sample FIFO as a one-sample-per-strobe x/x_is_valid stream with a programmable idle gap.
module sample_stream_tx
    import sample_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int GAP_W  = GAP_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   start,
    input  logic [GAP_W-1:0]       gap,
    output logic [DATA_W-1:0]      x,
    output logic                   x_is_valid,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   overflow,
    output logic [7:0]             sent_cnt
);

    localparam int LW = lvl_w(DEPTH);

    logic [DATA_W-1:0] head;
    logic [LW-1:0]     fifo_level;
    logic              fifo_full, fifo_empty;
    logic              emit, last;
    logic [GAP_W-1:0]  gap_eff;

    state_e            state_q, state_d;
    logic [GAP_W-1:0]  gap_r_q, gap_r_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]        sent_cnt_q, sent_cnt_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;

    sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (emit),
        .head      (head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The run ends only if nothing is being pushed alongside the final pop.
    assign last = (fifo_level == LW'(1)) && !wr_en;

    always_comb begin
        state_d    = state_q;
        gap_r_d    = gap_r_q;
        gap_cnt_d  = gap_cnt_q;
        sent_cnt_d = sent_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        emit       = 1'b0;
        gap_eff    = gap_r_q;
        case (state_q)
            ST_IDLE: begin
                // busy still high here means the previous cycle carried the final strobe.
                if (busy_q) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else if (start && !fifo_empty) begin
                    emit       = 1'b1;
                    gap_eff    = gap;
                    gap_r_d    = gap;
                    sent_cnt_d = 8'd0;
                    busy_d     = 1'b1;
                end
            end
            ST_EMIT: begin
                if (fifo_empty) state_d = ST_IDLE;
                else            emit    = 1'b1;
            end
            ST_GAP: begin
                if (gap_cnt_q <= GAP_W'(1)) state_d   = ST_EMIT;
                else                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        if (emit) begin
            sent_cnt_d = sent_cnt_d + 8'd1;
            if (last)                 state_d = ST_IDLE;
            else if (gap_eff == '0)   state_d = ST_EMIT;
            else begin
                state_d   = ST_GAP;
                gap_cnt_d = gap_eff;
            end
        end

        x_d        = emit ? head : '0;
        valid_d    = emit;
        overflow_d = overflow_q | (wr_en & fifo_full & ~emit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            gap_r_q    <= '0;
            gap_cnt_q  <= '0;
            sent_cnt_q <= '0;
            x_q        <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_r_q    <= gap_r_d;
            gap_cnt_q  <= gap_cnt_d;
            sent_cnt_q <= sent_cnt_d;
            x_q        <= x_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign x          = x_q;
    assign x_is_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign level      = fifo_level;
    assign full       = fifo_full;
    assign overflow   = overflow_q;
    assign sent_cnt   = sent_cnt_q;

endmodule

// File: tb/tb_sample_stream_tx.sv
// Directed bench for sample_stream_tx: each task drives one scenario and checks against hand-derived values.
module tb_sample_stream_tx;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 8;
    localparam int GAP_W  = 4;

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              wr_en   = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              start   = 1'b0;
    logic [GAP_W-1:0]  gap     = '0;
    logic [DATA_W-1:0] x;
    logic              x_is_valid, busy, done, full, overflow;
    logic [3:0]        level;
    logic [7:0]        sent_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    sample_stream_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .start      (start),
        .gap        (gap),
        .x          (x),
        .x_is_valid (x_is_valid),
        .busy       (busy),
        .done       (done),
        .level      (level),
        .full       (full),
        .overflow   (overflow),
        .sent_cnt   (sent_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic kick(input logic [GAP_W-1:0] g);
        gap   = g;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        vec_cnt++;
        if ({x, x_is_valid, busy, done, full, overflow} !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_ctrl: x=%0d v=%b busy=%b done=%b full=%b ovf=%b, required all 0",
                     x, x_is_valid, busy, done, full, overflow);
        end
        vec_cnt++;
        if (level !== 4'd0 || sent_cnt !== 8'd0) begin
            err_cnt++;
            $display("FAIL reset_cnt: level=%0d sent_cnt=%0d, required 0 0", level, sent_cnt);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp;
        for (int i = 3; i <= 8; i++) push(DATA_W'(i));
        vec_cnt++;
        if (level !== 4'd6 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_prefill: level=%0d busy=%b, required 6 0", level, busy);
        end
        kick(4'd0);
        vec_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_busy: busy=%b, required 1", busy);
        end
        for (int i = 0; i < 6; i++) begin
            exp = DATA_W'(3 + i);
            vec_cnt++;
            if (x_is_valid !== 1'b1 || x !== exp || done !== 1'b0) begin
                err_cnt++;
                $display("FAIL b2b_strobe%0d: valid=%b x=%0d done=%b, required 1 %0d 0",
                         i, x_is_valid, x, done, exp);
            end
            tick();
        end
        vec_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || x_is_valid !== 1'b0 || x !== 4'd0) begin
            err_cnt++;
            $display("FAIL b2b_done: done=%b busy=%b valid=%b x=%0d, required 1 0 0 0",
                     done, busy, x_is_valid, x);
        end
        vec_cnt++;
        if (level !== 4'd0 || sent_cnt !== 8'd6) begin
            err_cnt++;
            $display("FAIL b2b_counts: level=%0d sent_cnt=%0d, required 0 6", level, sent_cnt);
        end
        tick();
        vec_cnt++;
        if (done !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_done_pulse: done=%b, required 0", done);
        end
    endtask

    task automatic test_gap();
        logic [DATA_W-1:0] exp;
        for (int i = 1; i <= 3; i++) push(DATA_W'(i));
        kick(4'd2);
        for (int i = 0; i < 3; i++) begin
            exp = DATA_W'(i + 1);
            vec_cnt++;
            if (x_is_valid !== 1'b1 || x !== exp) begin
                err_cnt++;
                $display("FAIL gap_strobe%0d: valid=%b x=%0d, required 1 %0d", i, x_is_valid, x, exp);
            end
            if (i < 2) begin
                for (int j = 0; j < 2; j++) begin
                    tick();
                    vec_cnt++;
                    if (x_is_valid !== 1'b0 || x !== 4'd0 || busy !== 1'b1) begin
                        err_cnt++;
                        $display("FAIL gap_idle%0d_%0d: valid=%b x=%0d busy=%b, required 0 0 1",
                                 i, j, x_is_valid, x, busy);
                    end
                end
            end
            tick();
        end
        vec_cnt++;
        if (done !== 1'b1 || sent_cnt !== 8'd3) begin
            err_cnt++;
            $display("FAIL gap_done: done=%b sent_cnt=%0d, required 1 3", done, sent_cnt);
        end
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] exp;
        for (int i = 0; i < 8; i++) push(DATA_W'(i));
        vec_cnt++;
        if (full !== 1'b1 || level !== 4'd8 || overflow !== 1'b0) begin
            err_cnt++;
            $display("FAIL ovf_full: full=%b level=%0d ovf=%b, required 1 8 0", full, level, overflow);
        end
        push(4'd8);
        vec_cnt++;
        if (overflow !== 1'b1 || level !== 4'd8) begin
            err_cnt++;
            $display("FAIL ovf_drop: ovf=%b level=%0d, required 1 8", overflow, level);
        end
        kick(4'd0);
        for (int i = 0; i < 8; i++) begin
            exp = DATA_W'(i);
            vec_cnt++;
            if (x_is_valid !== 1'b1 || x !== exp) begin
                err_cnt++;
                $display("FAIL ovf_strobe%0d: valid=%b x=%0d, required 1 %0d", i, x_is_valid, x, exp);
            end
            tick();
        end
        vec_cnt++;
        if (x_is_valid !== 1'b0 || done !== 1'b1 || level !== 4'd0 || sent_cnt !== 8'd8) begin
            err_cnt++;
            $display("FAIL ovf_end: valid=%b done=%b level=%0d sent_cnt=%0d, required 0 1 0 8",
                     x_is_valid, done, level, sent_cnt);
        end
        tick();
    endtask

    task automatic test_push_during_emit();
        push(4'd5);
        push(4'd6);
        kick(4'd3);
        vec_cnt++;
        if (x_is_valid !== 1'b1 || x !== 4'd5) begin
            err_cnt++;
            $display("FAIL pde_first: valid=%b x=%0d, required 1 5", x_is_valid, x);
        end
        push(4'd7);
        vec_cnt++;
        if (level !== 4'd2 || x_is_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL pde_push: level=%0d valid=%b, required 2 0", level, x_is_valid);
        end
        repeat (3) tick();
        vec_cnt++;
        if (x_is_valid !== 1'b1 || x !== 4'd6 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL pde_second: valid=%b x=%0d done=%b, required 1 6 0", x_is_valid, x, done);
        end
        repeat (4) tick();
        vec_cnt++;
        if (x_is_valid !== 1'b1 || x !== 4'd7 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL pde_third: valid=%b x=%0d done=%b, required 1 7 0", x_is_valid, x, done);
        end
        tick();
        vec_cnt++;
        if (done !== 1'b1 || sent_cnt !== 8'd3) begin
            err_cnt++;
            $display("FAIL pde_done: done=%b sent_cnt=%0d, required 1 3", done, sent_cnt);
        end
        tick();
    endtask

    task automatic test_ignored_starts();
        kick(4'd0);
        vec_cnt++;
        if (x_is_valid !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL ign_empty: valid=%b busy=%b, required 0 0", x_is_valid, busy);
        end
        tick();
        vec_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || sent_cnt !== 8'd3) begin
            err_cnt++;
            $display("FAIL ign_empty_done: done=%b busy=%b sent_cnt=%0d, required 0 0 3", done, busy, sent_cnt);
        end
        for (int i = 1; i <= 3; i++) push(DATA_W'(i));
        kick(4'd1);
        vec_cnt++;
        if (x !== 4'd1 || sent_cnt !== 8'd1) begin
            err_cnt++;
            $display("FAIL ign_run_first: x=%0d sent_cnt=%0d, required 1 1", x, sent_cnt);
        end
        tick();
        kick(4'd0);
        vec_cnt++;
        if (x_is_valid !== 1'b1 || x !== 4'd2 || sent_cnt !== 8'd2) begin
            err_cnt++;
            $display("FAIL ign_midrun: valid=%b x=%0d sent_cnt=%0d, required 1 2 2", x_is_valid, x, sent_cnt);
        end
        repeat (2) tick();
        vec_cnt++;
        if (x_is_valid !== 1'b1 || x !== 4'd3 || sent_cnt !== 8'd3) begin
            err_cnt++;
            $display("FAIL ign_last: valid=%b x=%0d sent_cnt=%0d, required 1 3 3", x_is_valid, x, sent_cnt);
        end
        tick();
        vec_cnt++;
        if (done !== 1'b1) begin
            err_cnt++;
            $display("FAIL ign_done: done=%b, required 1", done);
        end
        tick();
    endtask

    task automatic test_async_reset();
        push(4'd2);
        push(4'd4);
        push(4'd6);
        push(4'd8);
        kick(4'd1);
        tick();
        tick();
        vec_cnt++;
        if (x_is_valid !== 1'b1 || x !== 4'd4) begin
            err_cnt++;
            $display("FAIL arst_pre: valid=%b x=%0d, required 1 4", x_is_valid, x);
        end
        #2 rst = 1'b0;
        #1;
        vec_cnt++;
        if ({x, x_is_valid, busy, done, full, overflow} !== 8'h00) begin
            err_cnt++;
            $display("FAIL arst_ctrl: x=%0d v=%b busy=%b done=%b full=%b ovf=%b, required all 0",
                     x, x_is_valid, busy, done, full, overflow);
        end
        vec_cnt++;
        if (level !== 4'd0 || sent_cnt !== 8'd0) begin
            err_cnt++;
            $display("FAIL arst_cnt: level=%0d sent_cnt=%0d, required 0 0", level, sent_cnt);
        end
        tick();
        rst = 1'b1;
        tick();
        vec_cnt++;
        if (done !== 1'b0 || x_is_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL arst_nodone: done=%b valid=%b, required 0 0", done, x_is_valid);
        end
        push(4'd9);
        kick(4'd0);
        vec_cnt++;
        if (x_is_valid !== 1'b1 || x !== 4'd9) begin
            err_cnt++;
            $display("FAIL arst_resume: valid=%b x=%0d, required 1 9", x_is_valid, x);
        end
        tick();
        vec_cnt++;
        if (done !== 1'b1 || sent_cnt !== 8'd1 || level !== 4'd0) begin
            err_cnt++;
            $display("FAIL arst_resume_done: done=%b sent_cnt=%0d level=%0d, required 1 1 0",
                     done, sent_cnt, level);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gap();
        test_overflow();
        test_push_during_emit();
        test_ignored_starts();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/sample_stream_tx.md
Name: sample_stream_tx

Overview:
- Transmit end of the 4-bit sample / x_is_valid stream that feeds the 4-tap moving-average blocks.
- The host pushes samples into a small internal FIFO and issues start.
- The block then emits the FIFO contents one sample per valid pulse, with a programmable idle gap between samples.
- It reports busy/done status, FIFO level and an overflow flag, so a bench or controller can drive the averager deterministically.

Parameters:
- DATA_W, 4, sample width; matches averager input x.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- GAP_W, 4, width of the inter-sample gap field.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- wr_en  in  1  push wr_data into FIFO this cycle.
- wr_data  in  DATA_W  sample to push.
- start  in  1  single-cycle request to begin emission.
- gap  in  GAP_W  idle cycles between consecutive valid pulses; sampled at start.
- x  out  DATA_W  emitted sample; 0 whenever x_is_valid is 0.
- x_is_valid  out  1  one-cycle strobe, x is valid.
- busy  out  1  high from the cycle after an accepted start until emission ends.
- done  out  1  one-cycle pulse when the FIFO drains during emission.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- full  out  1  level == DEPTH.
- overflow  out  1  sticky; set on a push that is dropped.
- sent_cnt  out  8  samples emitted since the last accepted start; wraps 255 -> 0.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO cleared; level = 0; full = 0; overflow = 0.
  - x = 0; x_is_valid = 0; busy = 0; done = 0; sent_cnt = 0.
  - State = IDLE; gap register = 0.
  - Reset mid-emission aborts immediately; no done pulse.
- All outputs are registered.
- State IDLE:
  - start with level > 0: latch gap into gap_r, clear sent_cnt, go to EMIT.
  - start with level == 0: ignored; no done pulse.
- State EMIT (one cycle):
  - x <= FIFO head; x_is_valid <= 1; pop; sent_cnt += 1.
  - The strobe appears on the cycle after the start cycle (start latency 1).
  - Exit when the popped entry was the last one (level will be 0 after this cycle's push/pop):
    - Go to IDLE.
    - done pulses on the cycle after the final x_is_valid; busy falls with it.
  - Otherwise, gap_r == 0: stay in EMIT, giving back-to-back valids.
  - Otherwise: go to GAP, loading gap counter = gap_r.
- State GAP:
  - x_is_valid = 0 and x = 0.
  - Counter decrements each cycle; at 1 go to EMIT.
  - Valid strobes are therefore spaced exactly gap_r + 1 cycles apart.
- Pushes:
  - Accepted in any state while not full.
  - Samples pushed during emission are emitted in the same run, since emission continues while level > 0.
  - A push in the same cycle as a pop while full is accepted; level is unchanged.
  - A push while full without a pop is dropped and sets overflow; overflow is cleared only by reset.
- start while busy is ignored. gap changes while busy have no effect.
- Order is FIFO; pointers wrap modulo DEPTH.

Decomposition:
- Package sample_stream_pkg holds:
  - DATA_W and DEPTH defaults.
  - State enum {IDLE, EMIT, GAP}.
  - Level width function.
- One sub-module: sample_fifo.
  - Synchronous push/pop; asynchronous active-low reset.
  - Outputs head, level, full, empty.
  - Simultaneous push+pop is legal at any level, including full; level stays unchanged.
- The FSM, gap counter, sent_cnt and output registers live in sample_stream_tx.

Test Plan:
- Back-to-back run: push 3,4,5,6,7,8; gap = 0; start.
  - x_is_valid high 6 consecutive cycles, starting 1 cycle after start, with x = 3,4,5,6,7,8.
  - done pulses the next cycle; level = 0; sent_cnt = 6.
- Gap spacing: push 1,2,3; gap = 2; start.
  - Valids 3 cycles apart with x = 1,2,3; x = 0 between strobes; done 1 cycle after the third strobe.
- Overflow: push 9 samples (0..8) with DEPTH 8.
  - full after the 8th push; 9th dropped; overflow = 1.
  - A subsequent run emits 0..7 only.
- Push during emission: push 5,6; gap = 3; start; push 7 during the first GAP.
  - Emits 5,6,7; done only after 7; sent_cnt = 3.
- Ignored starts:
  - start with empty FIFO: no valid, no done, busy stays 0.
  - start asserted mid-run: no restart, sent_cnt not cleared.
- Async reset mid-run: push 2,4,6,8; gap = 1; start; drop rst after the second strobe.
  - All outputs 0 immediately, without waiting for a clock edge; level = 0; no done.
  - After release, a new push of 9 plus start emits 9.
